dynode_event_arbiter: RTL and testbench
=======================================

// Module: dynode_event_arbiter
// PURPOSE
//  Collects event reports from NCH dynode event-detector channels (event pulse, 24-bit event time, pileup
//  flag) and serialises them onto one valid/ready stream for the coincidence logic. Each channel has a
//  one-entry holding slot. A round-robin arbiter fills a single output register. Entries older than
//  STALE_CYC are discarded. Lost events are flagged.
// PARAMETERS
//  NCH        4    number of dynode channels (2..8)
//  CHW        2    channel index width, >= clog2(NCH)
//  STALE_CYC  63   max cycles an entry may wait in its slot before discard (1..255)
// PORTS
//  clk          in   1       system clock
//  reset_n      in   1       asynchronous active-low reset
//  chan_enable  in   NCH     per-channel accept enable
//  ch_event     in   NCH     1-cycle event-detected pulse per channel
//  ch_evntim    in   NCH*24  event time; channel i in [24*i+23:24*i], valid with ch_event[i]
//  ch_pileup    in   NCH     pileup flag, sampled with ch_event[i]
//  out_ready    in   1       downstream accepts the output word
//  out_valid    out  1       output word valid
//  out_chan     out  CHW     channel index of output word
//  out_evntim   out  24      event time of output word
//  out_pileup   out  1       pileup flag of output word
//  pend         out  NCH     slot-occupied flags
//  drop_any     out  1       sticky: an event was lost (overflow or stale)
//  clr_drop     in   1       synchronous clear of drop_any (and the drop counters)
// BEHAVIOUR
//  - Reset (async, any time, including mid-transfer): out_valid=0, out_chan=0, out_evntim=0, out_pileup=0,
//    pend=0, drop_any=0, RR pointer=NCH-1, ages=0. Any word in flight is lost without a drop flag.
//  - Capture, cycle N: ch_event[i] & chan_enable[i].
//    - Slot i empty, or emptied by a grant in cycle N: slot loads {evntim, pileup}, age=0, pend[i]=1 at N+1.
//    - Slot i full and not granted: the new event is dropped, the old entry is kept, drop_any=1 at N+1.
//    - chan_enable[i]=0: event ignored, not counted as a drop.
//  - Output register is free when out_valid=0 or (out_valid & out_ready).
//  - Arbiter FSM, states ARB_IDLE and ARB_HOLD:
//    - ARB_IDLE -> ARB_HOLD when any pend bit is set. The winner loads the output register.
//    - ARB_HOLD -> ARB_HOLD when out_ready=1 and another slot is pending (back-to-back, one word per cycle).
//    - ARB_HOLD -> ARB_IDLE when out_ready=1 and nothing is pending. Stays in ARB_HOLD while out_ready=0.
//  - Round robin: search starts at ptr+1 mod NCH. The winner clears its pend bit and becomes ptr.
//  - Latency: event at N -> pend at N+1 -> out_valid at N+2 when the output register is free at N+1.
//  - Output fields hold stable while out_valid & !out_ready.
//  - Aging: an 8-bit age per occupied slot increments each cycle while the slot is not granted.
//    At age==STALE_CYC the slot clears, drop_any=1, and the slot is not granted that cycle.
//    A grant and the stale condition in the same cycle: the grant wins.
//  - clr_drop coinciding with a new drop: the set wins, drop_any=1.
//  - A channel disabled while its slot is pending: the entry stays and is still arbitrated.
//  - No combinational path from any input to any output.
// CONFIGURATION
//  DYN_ARB_DROPCNT_EN defined:
//    - Adds port drop_cnt, out, NCH*8: per-channel saturating 8-bit lost-event counters (overflow + stale).
//    - Counters saturate at 8'hFF, clear on reset and clr_drop. A new drop in the same cycle as clr_drop
//      gives 1.
//  DYN_ARB_DROPCNT_EN undefined:
//    - Port drop_cnt and its counters are absent; only drop_any reports losses.
// TESTING
//  1. Single event: ch_event[2] with evntim=24'h12_3A40, pileup=1, out_ready=1
//     -> out_valid at +2 for 1 cycle, out_chan=2, out_evntim=24'h123A40, out_pileup=1.
//  2. Simultaneous: ch_event=4'b1111, times 24'h000100..24'h000400, ptr=3, out_ready=1
//     -> 4 consecutive words, chan 0,1,2,3, times in order; no drops.
//  3. Backpressure: out_ready=0 for 10 cycles after an event on ch1, then a second event on ch1
//     -> the first word is held stable; the second event sits in slot 1; drop_any=0.
//     A third ch1 event before any accept -> drop_any=1, drop_cnt[ch1]=1 (with the macro).
//  4. Stale: out_ready=0, slot 0 pending, STALE_CYC=63 -> after 63 unserved cycles pend[0] falls and
//     drop_any rises. Slot 0 never appears on the output.
//  5. Same-cycle refill: slot 3 granted in the same cycle as a new ch_event[3]
//     -> new entry captured, pend[3] stays 1, no drop.
//  6. Async reset: assert reset_n=0 while out_valid=1 and pend=4'b1010
//     -> all outputs 0 immediately. After release: ARB_IDLE, first grant goes to ch0.

Source files
------------

// File: rtl/dynode_event_arbiter.sv
// Dynode event arbiter: one holding slot per channel with aging, round-robin onto a valid/ready stream.
// Define DYN_ARB_DROPCNT_EN to add per-channel saturating lost-event counters on port drop_cnt.
module dynode_event_arbiter #(
    parameter int NCH       = 4,
    parameter int CHW       = 2,
    parameter int STALE_CYC = 63
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NCH-1:0]    chan_enable,
    input  logic [NCH-1:0]    ch_event,
    input  logic [NCH*24-1:0] ch_evntim,
    input  logic [NCH-1:0]    ch_pileup,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [CHW-1:0]    out_chan,
    output logic [23:0]       out_evntim,
    output logic              out_pileup,
    output logic [NCH-1:0]    pend,
`ifdef DYN_ARB_DROPCNT_EN
    output logic [NCH*8-1:0]  drop_cnt,
`endif
    output logic              drop_any,
    input  logic              clr_drop
);

    typedef enum logic {ARB_IDLE, ARB_HOLD} arb_state_t;

    arb_state_t     r_state;
    arb_state_t     w_state_next;
    logic           w_load_out;
    logic [CHW-1:0] r_ptr;
    logic [CHW-1:0] r_out_chan;
    logic [23:0]    r_out_tim;
    logic           r_out_pu;
    logic           r_drop_any;

    logic           r_pend     [NCH];
    logic [23:0]    r_slot_tim [NCH];
    logic           r_slot_pu  [NCH];
    logic [7:0]     r_age      [NCH];

    logic [NCH-1:0] w_pend;
    logic [NCH-1:0] w_grant_vec;
    logic [NCH-1:0] w_stale;
    logic [NCH-1:0] w_ovf;
    logic           w_out_free;
    logic           w_grant;
    logic [CHW-1:0] w_win_idx;

    function automatic logic [CHW-1:0] rr_idx(input logic [CHW-1:0] base, input int k);
        int sum;
        sum = (int'(base) + k) % NCH;
        return CHW'(sum);
    endfunction

    assign w_out_free = (r_state == ARB_IDLE) || out_ready;

    // Search starts one past the last winner so every channel gets a turn.
    always_comb begin
        w_grant     = 1'b0;
        w_win_idx   = '0;
        w_grant_vec = '0;
        if (w_out_free) begin
            for (int k = 1; k <= NCH; k++) begin
                if (!w_grant && w_pend[rr_idx(r_ptr, k)]) begin
                    w_grant   = 1'b1;
                    w_win_idx = rr_idx(r_ptr, k);
                end
            end
        end
        if (w_grant) begin
            w_grant_vec[w_win_idx] = 1'b1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load_out   = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (w_grant) begin
                    w_state_next = ARB_HOLD;
                    w_load_out   = 1'b1;
                end
            end
            ARB_HOLD: begin
                if (out_ready) begin
                    if (w_grant) begin
                        w_load_out = 1'b1;
                    end else begin
                        w_state_next = ARB_IDLE;
                    end
                end
            end
            default: w_state_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ARB_IDLE;
            r_ptr      <= CHW'(NCH - 1);
            r_out_chan <= '0;
            r_out_tim  <= '0;
            r_out_pu   <= 1'b0;
            r_drop_any <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_drop_any <= (clr_drop ? 1'b0 : r_drop_any) | (|(w_ovf | w_stale));
            if (w_load_out) begin
                r_ptr      <= w_win_idx;
                r_out_chan <= w_win_idx;
                r_out_tim  <= r_slot_tim[w_win_idx];
                r_out_pu   <= r_slot_pu[w_win_idx];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_slot
            logic w_cap;
            logic w_load;

            assign w_cap       = ch_event[gi] & chan_enable[gi];
            // A slot being granted this cycle is free to take a new event.
            assign w_load      = w_cap & (~r_pend[gi] | w_grant_vec[gi]);
            assign w_ovf[gi]   = w_cap & r_pend[gi] & ~w_grant_vec[gi];
            assign w_stale[gi] = r_pend[gi] & (r_age[gi] == 8'(STALE_CYC)) & ~w_grant_vec[gi];
            assign w_pend[gi]  = r_pend[gi];

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_pend[gi]     <= 1'b0;
                    r_age[gi]      <= '0;
                    r_slot_tim[gi] <= '0;
                    r_slot_pu[gi]  <= 1'b0;
                end else if (w_load) begin
                    r_pend[gi]     <= 1'b1;
                    r_age[gi]      <= '0;
                    r_slot_tim[gi] <= ch_evntim[gi*24 +: 24];
                    r_slot_pu[gi]  <= ch_pileup[gi];
                end else if (w_grant_vec[gi] || w_stale[gi]) begin
                    r_pend[gi]     <= 1'b0;
                    r_age[gi]      <= '0;
                end else if (r_pend[gi]) begin
                    r_age[gi]      <= r_age[gi] + 8'd1;
                end
            end

`ifdef DYN_ARB_DROPCNT_EN
            logic [7:0] r_cnt;
            logic [1:0] w_inc;
            logic [8:0] w_sum;

            // Overflow and stale can both hit one channel in the same cycle.
            assign w_inc = {1'b0, w_ovf[gi]} + {1'b0, w_stale[gi]};
            assign w_sum = (clr_drop ? 9'd0 : {1'b0, r_cnt}) + {7'd0, w_inc};

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= w_sum[8] ? 8'hFF : w_sum[7:0];
                end
            end

            assign drop_cnt[gi*8 +: 8] = r_cnt;
`endif
        end
    endgenerate

    assign out_valid  = (r_state == ARB_HOLD);
    assign out_chan   = r_out_chan;
    assign out_evntim = r_out_tim;
    assign out_pileup = r_out_pu;
    assign pend       = w_pend;
    assign drop_any   = r_drop_any;

endmodule

// File: tb/tb_dynode_event_arbiter.sv
// Testbench for dynode_event_arbiter: directed scenarios plus randomized traffic against a reference model.
module tb_dynode_event_arbiter;

    localparam int NCH   = 4;
    localparam int CHW   = 2;
    localparam int STALE = 63;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [NCH-1:0]    chan_enable;
    logic [NCH-1:0]    ch_event;
    logic [NCH*24-1:0] ch_evntim;
    logic [NCH-1:0]    ch_pileup;
    logic              out_ready;
    logic              clr_drop;
    logic              out_valid;
    logic [CHW-1:0]    out_chan;
    logic [23:0]       out_evntim;
    logic              out_pileup;
    logic [NCH-1:0]    pend;
    logic              drop_any;
`ifdef DYN_ARB_DROPCNT_EN
    logic [NCH*8-1:0]  drop_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dynode_event_arbiter #(.NCH(NCH), .CHW(CHW), .STALE_CYC(STALE)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .chan_enable(chan_enable),
        .ch_event   (ch_event),
        .ch_evntim  (ch_evntim),
        .ch_pileup  (ch_pileup),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_chan   (out_chan),
        .out_evntim (out_evntim),
        .out_pileup (out_pileup),
        .pend       (pend),
`ifdef DYN_ARB_DROPCNT_EN
        .drop_cnt   (drop_cnt),
`endif
        .drop_any   (drop_any),
        .clr_drop   (clr_drop)
    );

    // Reference model: slots, output word and loss bookkeeping as described by the arbitration rules.
    bit          m_full [NCH];
    logic [23:0] m_tim  [NCH];
    bit          m_pu   [NCH];
    int          m_wait [NCH];
    int          m_cnt  [NCH];
    int          m_ptr;
    bit          m_ov;
    int          m_oc;
    logic [23:0] m_ot;
    bit          m_op;
    bit          m_drop;

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_full[i] = 0; m_tim[i] = '0; m_pu[i] = 0; m_wait[i] = 0; m_cnt[i] = 0;
        end
        m_ptr = NCH - 1; m_ov = 0; m_oc = 0; m_ot = '0; m_op = 0; m_drop = 0;
    endtask

    task automatic model_step();
        int  win;
        int  lost;
        bit  any_lost;
        bit  granted;
        bit  cap;
        bit  stale;
        win = -1;
        any_lost = 0;
        if (!m_ov || out_ready) begin
            for (int k = 1; k <= NCH; k++) begin
                int c;
                c = (m_ptr + k) % NCH;
                if (win < 0 && m_full[c]) win = c;
            end
        end
        if (win >= 0) begin
            m_ov = 1; m_oc = win; m_ot = m_tim[win]; m_op = m_pu[win]; m_ptr = win;
        end else if (out_ready) begin
            m_ov = 0;
        end
        for (int i = 0; i < NCH; i++) begin
            lost    = 0;
            granted = (i == win);
            cap     = ch_event[i] && chan_enable[i];
            stale   = m_full[i] && !granted && (m_wait[i] == STALE);
            if (cap && (!m_full[i] || granted)) begin
                m_full[i] = 1; m_wait[i] = 0;
                m_tim[i]  = ch_evntim[i*24 +: 24]; m_pu[i] = ch_pileup[i];
            end else begin
                if (cap) lost++;
                if (stale) begin
                    lost++; m_full[i] = 0; m_wait[i] = 0;
                end else if (granted) begin
                    m_full[i] = 0; m_wait[i] = 0;
                end else if (m_full[i]) begin
                    m_wait[i]++;
                end
            end
            if (lost > 0) any_lost = 1;
            m_cnt[i] = (clr_drop ? 0 : m_cnt[i]) + lost;
            if (m_cnt[i] > 255) m_cnt[i] = 255;
        end
        m_drop = (clr_drop ? 1'b0 : m_drop) | any_lost;
    endtask

    task automatic clear_inputs();
        chan_enable = '1; ch_event = '0; ch_evntim = '0; ch_pileup = '0;
        out_ready = 1'b0; clr_drop = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic set_event(input int ch, input logic [23:0] tim, input logic pu);
        ch_event[ch]           = 1'b1;
        ch_evntim[ch*24 +: 24] = tim;
        ch_pileup[ch]          = pu;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (out_valid !== 1'b0 || out_chan !== 2'd0 || out_evntim !== 24'd0 || out_pileup !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out: got v=%b c=%0d t=%h p=%b expected all zero", out_valid, out_chan, out_evntim, out_pileup);
        end
        n_checks++;
        if (pend !== 4'b0000 || drop_any !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_pend: got pend=%b drop=%b expected 0000/0", pend, drop_any);
        end
        $display("reset: pend=%b out_valid=%b", pend, out_valid);
    endtask

    task automatic test_single_event();
        do_reset();
        out_ready = 1'b1;
        set_event(2, 24'h123A40, 1'b1);
        cyc();
        ch_event = '0;
        n_checks++;
        if (pend !== 4'b0100 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_capture: got pend=%b v=%b expected 0100/0", pend, out_valid);
        end
        cyc();
        n_checks++;
        if (out_valid !== 1'b1 || out_chan !== 2'd2 || out_evntim !== 24'h123A40 || out_pileup !== 1'b1) begin
            n_fail++;
            $display("FAIL single_word: got v=%b c=%0d t=%h p=%b expected 1/2/123a40/1", out_valid, out_chan, out_evntim, out_pileup);
        end
        cyc();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_oneshot: got v=%b expected 0", out_valid);
        end
        $display("single: chan=%0d time=%h", out_chan, out_evntim);
    endtask

    task automatic test_simultaneous();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < NCH; i++) set_event(i, 24'((i + 1) * 256), 1'b0);
        cyc();
        ch_event = '0;
        n_checks++;
        if (pend !== 4'b1111) begin
            n_fail++;
            $display("FAIL simul_pend: got %b expected 1111", pend);
        end
        for (int k = 0; k < NCH; k++) begin
            cyc();
            n_checks++;
            if (out_valid !== 1'b1 || out_chan !== CHW'(k) || out_evntim !== 24'((k + 1) * 256)) begin
                n_fail++;
                $display("FAIL simul_word%0d: got v=%b c=%0d t=%h expected 1/%0d/%h", k, out_valid, out_chan, out_evntim, k, 24'((k + 1) * 256));
            end
            $display("simultaneous: word %0d chan=%0d time=%h", k, out_chan, out_evntim);
        end
        cyc();
        n_checks++;
        if (out_valid !== 1'b0 || drop_any !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_end: got v=%b drop=%b expected 0/0", out_valid, drop_any);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        set_event(1, 24'hAAA001, 1'b0);
        cyc();
        ch_event = '0;
        cyc();
        n_checks++;
        if (out_valid !== 1'b1 || out_chan !== 2'd1 || out_evntim !== 24'hAAA001 || pend !== 4'b0000) begin
            n_fail++;
            $display("FAIL bp_first: got v=%b c=%0d t=%h pend=%b expected 1/1/aaa001/0000", out_valid, out_chan, out_evntim, pend);
        end
        for (int k = 0; k < 10; k++) begin
            cyc();
            n_checks++;
            if (out_valid !== 1'b1 || out_evntim !== 24'hAAA001) begin
                n_fail++;
                $display("FAIL bp_hold%0d: got v=%b t=%h expected 1/aaa001", k, out_valid, out_evntim);
            end
        end
        set_event(1, 24'hBBB002, 1'b1);
        cyc();
        n_checks++;
        if (pend !== 4'b0010 || drop_any !== 1'b0 || out_evntim !== 24'hAAA001) begin
            n_fail++;
            $display("FAIL bp_second: got pend=%b drop=%b t=%h expected 0010/0/aaa001", pend, drop_any, out_evntim);
        end
        set_event(1, 24'hCCC003, 1'b0);
        cyc();
        ch_event = '0;
        n_checks++;
        if (drop_any !== 1'b1 || pend !== 4'b0010 || out_evntim !== 24'hAAA001) begin
            n_fail++;
            $display("FAIL bp_overflow: got drop=%b pend=%b t=%h expected 1/0010/aaa001", drop_any, pend, out_evntim);
        end
`ifdef DYN_ARB_DROPCNT_EN
        n_checks++;
        if (drop_cnt[15:8] !== 8'd1) begin
            n_fail++;
            $display("FAIL bp_dropcnt: got %0d expected 1", drop_cnt[15:8]);
        end
`endif
        out_ready = 1'b1;
        cyc();
        n_checks++;
        if (out_valid !== 1'b1 || out_evntim !== 24'hBBB002 || out_pileup !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_kept: got v=%b t=%h p=%b expected 1/bbb002/1", out_valid, out_evntim, out_pileup);
        end
        cyc();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_drain: got v=%b expected 0", out_valid);
        end
        clr_drop = 1'b1;
        cyc();
        clr_drop = 1'b0;
        n_checks++;
        if (drop_any !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_clr_drop: got %b expected 0", drop_any);
        end
        $display("backpressure: last time=%h drop_any=%b", out_evntim, drop_any);
    endtask

    task automatic test_stale();
        do_reset();
        set_event(1, 24'h000111, 1'b0);
        cyc();
        ch_event = '0;
        cyc();
        set_event(0, 24'h000222, 1'b0);
        cyc();
        ch_event = '0;
        n_checks++;
        if (pend !== 4'b0001 || out_chan !== 2'd1) begin
            n_fail++;
            $display("FAIL stale_setup: got pend=%b c=%0d expected 0001/1", pend, out_chan);
        end
        for (int k = 1; k <= STALE; k++) begin
            cyc();
            if (pend[0] !== 1'b1 || drop_any !== 1'b0) begin
                n_checks++;
                n_fail++;
                $display("FAIL stale_early%0d: got pend0=%b drop=%b expected 1/0", k, pend[0], drop_any);
            end
        end
        n_checks++;
        cyc();
        if (pend[0] !== 1'b0 || drop_any !== 1'b1) begin
            n_fail++;
            $display("FAIL stale_expire: got pend0=%b drop=%b expected 0/1", pend[0], drop_any);
        end
        out_ready = 1'b1;
        cyc();
        cyc();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stale_never_out: got v=%b c=%0d expected 0", out_valid, out_chan);
        end
`ifdef DYN_ARB_DROPCNT_EN
        n_checks++;
        if (drop_cnt[7:0] !== 8'd1) begin
            n_fail++;
            $display("FAIL stale_dropcnt: got %0d expected 1", drop_cnt[7:0]);
        end
`endif
        $display("stale: pend=%b drop_any=%b", pend, drop_any);
    endtask

    task automatic test_same_cycle_refill();
        do_reset();
        out_ready = 1'b1;
        set_event(3, 24'h333001, 1'b0);
        cyc();
        set_event(3, 24'h333002, 1'b1);
        cyc();
        ch_event = '0;
        n_checks++;
        if (out_valid !== 1'b1 || out_chan !== 2'd3 || out_evntim !== 24'h333001 || pend !== 4'b1000 || drop_any !== 1'b0) begin
            n_fail++;
            $display("FAIL refill_first: got v=%b c=%0d t=%h pend=%b drop=%b expected 1/3/333001/1000/0", out_valid, out_chan, out_evntim, pend, drop_any);
        end
        cyc();
        n_checks++;
        if (out_valid !== 1'b1 || out_evntim !== 24'h333002 || out_pileup !== 1'b1 || pend !== 4'b0000) begin
            n_fail++;
            $display("FAIL refill_second: got v=%b t=%h p=%b pend=%b expected 1/333002/1/0000", out_valid, out_evntim, out_pileup, pend);
        end
        $display("refill: time=%h drop_any=%b", out_evntim, drop_any);
    endtask

    task automatic test_async_reset();
        do_reset();
        set_event(0, 24'h000AB1, 1'b1);
        cyc();
        ch_event = '0;
        cyc();
        set_event(1, 24'h000AB2, 1'b0);
        set_event(3, 24'h000AB3, 1'b0);
        cyc();
        ch_event = '0;
        n_checks++;
        if (out_valid !== 1'b1 || pend !== 4'b1010) begin
            n_fail++;
            $display("FAIL areset_setup: got v=%b pend=%b expected 1/1010", out_valid, pend);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_chan !== 2'd0 || out_evntim !== 24'd0 || out_pileup !== 1'b0 || pend !== 4'b0000 || drop_any !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_immediate: got v=%b c=%0d t=%h p=%b pend=%b drop=%b expected all zero", out_valid, out_chan, out_evntim, out_pileup, pend, drop_any);
        end
        @(posedge clk);
        #1;
        reset_n   = 1'b1;
        out_ready = 1'b1;
        cyc();
        n_checks++;
        if (out_valid !== 1'b0 || pend !== 4'b0000) begin
            n_fail++;
            $display("FAIL areset_idle: got v=%b pend=%b expected 0/0000", out_valid, pend);
        end
        set_event(0, 24'h000C00, 1'b0);
        set_event(2, 24'h000C02, 1'b0);
        cyc();
        ch_event = '0;
        cyc();
        n_checks++;
        if (out_valid !== 1'b1 || out_chan !== 2'd0 || out_evntim !== 24'h000C00) begin
            n_fail++;
            $display("FAIL areset_first_grant: got v=%b c=%0d t=%h expected 1/0/000c00", out_valid, out_chan, out_evntim);
        end
        $display("async reset: first grant chan=%0d", out_chan);
    endtask

    task automatic test_random();
        int pcts [4];
        int pct;
        int shown;
        logic [NCH-1:0] m_pend_vec;
        pcts  = '{90, 50, 10, 0};
        pct   = 90;
        shown = 0;
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 0) pct = pcts[$urandom_range(3)];
            for (int i = 0; i < NCH; i++) begin
                chan_enable[i]         = ($urandom_range(99) < 85);
                ch_event[i]            = ($urandom_range(99) < 25);
                ch_evntim[i*24 +: 24]  = 24'($urandom);
                ch_pileup[i]           = 1'($urandom);
            end
            out_ready = ($urandom_range(99) < pct);
            clr_drop  = ($urandom_range(99) < 2);
            @(posedge clk);
            model_step();
            #1;
            for (int i = 0; i < NCH; i++) m_pend_vec[i] = m_full[i];
            n_checks++;
            if (out_valid !== m_ov || out_chan !== CHW'(m_oc) || out_evntim !== m_ot || out_pileup !== m_op) begin
                n_fail++;
                if (shown < 20) $display("FAIL rand_out cyc %0d: got v=%b c=%0d t=%h p=%b expected v=%b c=%0d t=%h p=%b", c, out_valid, out_chan, out_evntim, out_pileup, m_ov, m_oc, m_ot, m_op);
                shown++;
            end
            n_checks++;
            if (pend !== m_pend_vec || drop_any !== m_drop) begin
                n_fail++;
                if (shown < 20) $display("FAIL rand_pend cyc %0d: got pend=%b drop=%b expected pend=%b drop=%b", c, pend, drop_any, m_pend_vec, m_drop);
                shown++;
            end
`ifdef DYN_ARB_DROPCNT_EN
            for (int i = 0; i < NCH; i++) begin
                n_checks++;
                if (drop_cnt[i*8 +: 8] !== 8'(m_cnt[i])) begin
                    n_fail++;
                    if (shown < 20) $display("FAIL rand_cnt%0d cyc %0d: got %0d expected %0d", i, c, drop_cnt[i*8 +: 8], m_cnt[i]);
                    shown++;
                end
            end
`endif
            if (c % 500 == 0) $display("random: cycle %0d ready%%=%0d v=%b pend=%b drop=%b", c, pct, out_valid, pend, drop_any);
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        reset_n = 1'b0;
        test_reset();
        test_single_event();
        test_simultaneous();
        test_backpressure();
        test_stale();
        test_same_cycle_refill();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
